// File: rtl/msp_v2_handler.sv
// MSP v1/v2 request parser and reply generator between a PC UART byte stream and FC status.
// Replies are built on the fly from a byte mux; no frame buffer is kept.
module msp_v2_handler #(
  parameter int unsigned CLK_FREQ_HZ = 72_000_000,
  parameter int unsigned MAX_PAYLOAD = 64,
  parameter int unsigned TIMEOUT_MS  = 10,
  parameter bit          ENABLE_V2   = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_pc_rx_data,
  input  logic        i_pc_rx_valid,
  output logic [7:0]  o_pc_tx_data,
  output logic        o_pc_tx_valid,
  input  logic        i_pc_tx_ready,
  output logic        o_active,
  input  logic [7:0]  i_fc_version_major,
  input  logic [7:0]  i_fc_version_minor,
  input  logic [7:0]  i_fc_version_patch,
  input  logic [31:0] i_api_version,
  input  logic [31:0] i_fc_variant,
  output logic        o_passthrough_req,
  output logic [7:0]  o_passthrough_arg,
  output logic [15:0] o_frame_err_count
);

  localparam int unsigned ToCyc  = CLK_FREQ_HZ / 1000 * TIMEOUT_MS;
  localparam int unsigned ToW    = (ToCyc > 2) ? $clog2(ToCyc) : 1;
  localparam logic [ToW-1:0] ToLast = ToW'(ToCyc - 1);
  localparam logic [15:0] MaxLen = 16'(MAX_PAYLOAD);

  typedef enum logic [3:0] {
    StIdle, StHdr, StDir, StV1Len, StV1Cmd, StV2Flag, StV2Cmd0, StV2Cmd1,
    StV2Len0, StV2Len1, StPayload, StCheck, StResp, StTx
  } state_e;

  function automatic logic [7:0] crc8_d5(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'hD5) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  state_e         r_state, w_state_next;
  logic           r_v2;
  logic [15:0]    r_cmd;
  logic [7:0]     r_rx_len, r_rx_cnt, r_rx_ck, r_rx_b0;
  logic [ToW-1:0] r_to_cnt;
  logic [7:0]     r_tx_data, r_tx_idx, r_tx_ck;
  logic           r_tx_valid, r_active, r_pt_req;
  logic [7:0]     r_pt_arg;
  logic [15:0]    r_err_cnt;

  logic       w_err, w_to_active, w_timeout, w_known, w_in_ck, w_tx_done, w_tx_fire;
  logic [7:0] w_rx_fold, w_tx_fold, w_plen, w_rlen, w_dir, w_hdr_len, w_ck_idx;
  logic [7:0] w_pay_idx, w_pay_byte, w_frame_byte;
  logic       w_unused;

  assign w_unused = ^i_api_version[31:16];

  assign w_to_active = !(r_state inside {StIdle, StResp, StTx});
  assign w_timeout   = w_to_active && !i_pc_rx_valid && (r_to_cnt == ToLast);
  assign w_rx_fold   = r_v2 ? crc8_d5(r_rx_ck, i_pc_rx_data) : (r_rx_ck ^ i_pc_rx_data);

  // Reply shape: known commands carry a payload, unknown ones get an empty '!' frame.
  always_comb begin
    w_known = 1'b1;
    w_plen  = 8'd0;
    if (r_cmd[15:8] != 8'h00) begin
      w_known = 1'b0;
    end else begin
      case (r_cmd[7:0])
        8'd1:    w_plen = 8'd3;
        8'd2:    w_plen = 8'd4;
        8'd3:    w_plen = 8'd3;
        8'd100:  w_plen = 8'd7;
        8'd101:  w_plen = 8'd10;
        8'd245:  w_plen = 8'd1;
        default: w_known = 1'b0;
      endcase
    end
  end

  assign w_rlen    = w_known ? w_plen : 8'd0;
  assign w_dir     = w_known ? 8'h3E : 8'h21;
  assign w_hdr_len = r_v2 ? 8'd8 : 8'd5;
  assign w_ck_idx  = w_hdr_len + w_rlen;
  assign w_pay_idx = r_tx_idx - w_hdr_len;
  assign w_tx_fire = (r_state == StTx) && r_tx_valid && i_pc_tx_ready;
  assign w_tx_done = (r_tx_idx == w_ck_idx + 8'd1);

  always_comb begin
    w_pay_byte = 8'h00;
    case (r_cmd[7:0])
      8'd1: begin
        case (w_pay_idx[1:0])
          2'd0:    w_pay_byte = 8'h01;
          2'd1:    w_pay_byte = i_api_version[7:0];
          2'd2:    w_pay_byte = i_api_version[15:8];
          default: w_pay_byte = 8'h00;
        endcase
      end
      8'd2: begin
        case (w_pay_idx[1:0])
          2'd0:    w_pay_byte = i_fc_variant[7:0];
          2'd1:    w_pay_byte = i_fc_variant[15:8];
          2'd2:    w_pay_byte = i_fc_variant[23:16];
          default: w_pay_byte = i_fc_variant[31:24];
        endcase
      end
      8'd3: begin
        case (w_pay_idx[1:0])
          2'd0:    w_pay_byte = i_fc_version_major;
          2'd1:    w_pay_byte = i_fc_version_minor;
          2'd2:    w_pay_byte = i_fc_version_patch;
          default: w_pay_byte = 8'h00;
        endcase
      end
      8'd100:  w_pay_byte = (w_pay_idx == 8'd0) ? 8'h01 : 8'h00;
      8'd245:  w_pay_byte = r_pt_arg;
      default: w_pay_byte = 8'h00;
    endcase
  end

  // Byte at r_tx_idx of the reply frame; checksum covers everything after the direction byte.
  always_comb begin
    w_frame_byte = w_pay_byte;
    w_in_ck      = (r_tx_idx >= 8'd3);
    if (r_tx_idx == w_ck_idx) begin
      w_frame_byte = r_tx_ck;
      w_in_ck      = 1'b0;
    end else if (r_v2) begin
      case (r_tx_idx)
        8'd0:    w_frame_byte = 8'h24;
        8'd1:    w_frame_byte = 8'h58;
        8'd2:    w_frame_byte = w_dir;
        8'd3:    w_frame_byte = 8'h00;
        8'd4:    w_frame_byte = r_cmd[7:0];
        8'd5:    w_frame_byte = r_cmd[15:8];
        8'd6:    w_frame_byte = w_rlen;
        8'd7:    w_frame_byte = 8'h00;
        default: w_frame_byte = w_pay_byte;
      endcase
    end else begin
      case (r_tx_idx)
        8'd0:    w_frame_byte = 8'h24;
        8'd1:    w_frame_byte = 8'h4D;
        8'd2:    w_frame_byte = w_dir;
        8'd3:    w_frame_byte = w_rlen;
        8'd4:    w_frame_byte = r_cmd[7:0];
        default: w_frame_byte = w_pay_byte;
      endcase
    end
  end

  assign w_tx_fold = r_v2 ? crc8_d5(r_tx_ck, w_frame_byte) : (r_tx_ck ^ w_frame_byte);

  always_comb begin
    w_state_next = r_state;
    w_err        = 1'b0;
    case (r_state)
      StIdle: if (i_pc_rx_valid && i_pc_rx_data == 8'h24) w_state_next = StHdr;
      StHdr: if (i_pc_rx_valid) begin
        if (i_pc_rx_data == 8'h4D || (ENABLE_V2 && i_pc_rx_data == 8'h58)) w_state_next = StDir;
        else w_state_next = StIdle;
      end
      StDir: if (i_pc_rx_valid) begin
        if (i_pc_rx_data == 8'h3C)      w_state_next = r_v2 ? StV2Flag : StV1Len;
        else if (i_pc_rx_data == 8'h24) w_state_next = StHdr;
        else                            w_state_next = StIdle;
      end
      StV1Len: if (i_pc_rx_valid) begin
        if ({8'h00, i_pc_rx_data} > MaxLen) begin
          w_state_next = StIdle;
          w_err        = 1'b1;
        end else begin
          w_state_next = StV1Cmd;
        end
      end
      StV1Cmd:  if (i_pc_rx_valid) w_state_next = (r_rx_len == 8'd0) ? StCheck : StPayload;
      StV2Flag: if (i_pc_rx_valid) w_state_next = StV2Cmd0;
      StV2Cmd0: if (i_pc_rx_valid) w_state_next = StV2Cmd1;
      StV2Cmd1: if (i_pc_rx_valid) w_state_next = StV2Len0;
      StV2Len0: if (i_pc_rx_valid) w_state_next = StV2Len1;
      StV2Len1: if (i_pc_rx_valid) begin
        if ({i_pc_rx_data, r_rx_len} > MaxLen) begin
          w_state_next = StIdle;
          w_err        = 1'b1;
        end else begin
          w_state_next = (r_rx_len == 8'd0) ? StCheck : StPayload;
        end
      end
      StPayload: if (i_pc_rx_valid && r_rx_cnt == r_rx_len - 8'd1) w_state_next = StCheck;
      StCheck: if (i_pc_rx_valid) begin
        if (i_pc_rx_data == r_rx_ck) begin
          w_state_next = StResp;
        end else begin
          w_state_next = StIdle;
          w_err        = 1'b1;
        end
      end
      StResp:  w_state_next = StTx;
      StTx:    if (w_tx_fire && w_tx_done) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
    if (w_timeout) w_state_next = StIdle;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_v2       <= 1'b0;
      r_cmd      <= 16'h0000;
      r_rx_len   <= 8'h00;
      r_rx_cnt   <= 8'h00;
      r_rx_ck    <= 8'h00;
      r_rx_b0    <= 8'h00;
      r_to_cnt   <= '0;
      r_tx_data  <= 8'h00;
      r_tx_idx   <= 8'h00;
      r_tx_ck    <= 8'h00;
      r_tx_valid <= 1'b0;
      r_active   <= 1'b0;
      r_pt_req   <= 1'b0;
      r_pt_arg   <= 8'h00;
      r_err_cnt  <= 16'h0000;
    end else begin
      r_state  <= w_state_next;
      r_active <= (w_state_next != StIdle);
      r_pt_req <= 1'b0;
      r_to_cnt <= (!w_to_active || i_pc_rx_valid || w_timeout) ? '0 : r_to_cnt + ToW'(1);
      if (w_err && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
      if (i_pc_rx_valid && w_to_active) begin
        case (r_state)
          StHdr: r_v2 <= (i_pc_rx_data == 8'h58);
          StDir: begin
            r_rx_ck  <= 8'h00;
            r_rx_cnt <= 8'h00;
          end
          StV1Len: begin
            r_rx_len <= i_pc_rx_data;
            r_rx_ck  <= w_rx_fold;
          end
          StV1Cmd: begin
            r_cmd   <= {8'h00, i_pc_rx_data};
            r_rx_ck <= w_rx_fold;
          end
          StV2Flag, StV2Len1: r_rx_ck <= w_rx_fold;
          StV2Cmd0: begin
            r_cmd[7:0] <= i_pc_rx_data;
            r_rx_ck    <= w_rx_fold;
          end
          StV2Cmd1: begin
            r_cmd[15:8] <= i_pc_rx_data;
            r_rx_ck     <= w_rx_fold;
          end
          StV2Len0: begin
            r_rx_len <= i_pc_rx_data;
            r_rx_ck  <= w_rx_fold;
          end
          StPayload: begin
            if (r_rx_cnt == 8'd0) r_rx_b0 <= i_pc_rx_data;
            r_rx_cnt <= r_rx_cnt + 8'd1;
            r_rx_ck  <= w_rx_fold;
          end
          StCheck: begin
            if (w_state_next == StResp && r_cmd == 16'd245) begin
              r_pt_arg <= (r_rx_len != 8'd0) ? r_rx_b0 : 8'hFF;
            end
          end
          default: ;
        endcase
      end
      if (r_state == StResp) begin
        r_tx_data  <= 8'h24;
        r_tx_valid <= 1'b1;
        r_tx_idx   <= 8'd1;
        r_tx_ck    <= 8'h00;
      end
      // Next byte loads on the accepting edge so transfers can run back-to-back.
      if (w_tx_fire) begin
        if (w_tx_done) begin
          r_tx_valid <= 1'b0;
          r_pt_req   <= (r_cmd == 16'd245);
        end else begin
          r_tx_data <= w_frame_byte;
          r_tx_idx  <= r_tx_idx + 8'd1;
          if (w_in_ck) r_tx_ck <= w_tx_fold;
        end
      end
    end
  end

  assign o_pc_tx_data      = r_tx_data;
  assign o_pc_tx_valid     = r_tx_valid;
  assign o_active          = r_active;
  assign o_passthrough_req = r_pt_req;
  assign o_passthrough_arg = r_pt_arg;
  assign o_frame_err_count = r_err_cnt;

endmodule

// File: tb/tb_msp_v2_handler.sv
// Directed table-driven bench for msp_v2_handler: v1/v2 replies, errors, timeout and reset.
module tb_msp_v2_handler;

  logic        clk = 1'b0;
  logic        rst, rx_valid, tx_ready, tx_valid, active, pt_req;
  logic [7:0]  rx_data, tx_data, pt_arg;
  logic [15:0] err_cnt;
  logic [31:0] api, variant;

  always #5 clk = ~clk;

  msp_v2_handler #(
    .CLK_FREQ_HZ(1_000_000),
    .MAX_PAYLOAD(64),
    .TIMEOUT_MS (1),
    .ENABLE_V2  (1'b1)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_pc_rx_data      (rx_data),
    .i_pc_rx_valid     (rx_valid),
    .o_pc_tx_data      (tx_data),
    .o_pc_tx_valid     (tx_valid),
    .i_pc_tx_ready     (tx_ready),
    .o_active          (active),
    .i_fc_version_major(8'd4),
    .i_fc_version_minor(8'd5),
    .i_fc_version_patch(8'd1),
    .i_api_version     (api),
    .i_fc_variant      (variant),
    .o_passthrough_req (pt_req),
    .o_passthrough_arg (pt_arg),
    .o_frame_err_count (err_cnt)
  );

  typedef struct {
    logic [255:0] req;
    int           req_len;
    logic [255:0] rsp;
    int           rsp_len;
    int           mode;
    logic [15:0]  err;
    logic [7:0]   arg;
    int           pulse;
  } vec_t;

  vec_t       vecs[16];
  int         n_pass = 0;
  int         n_total = 0;
  logic [7:0] rx_buf[32];
  int         rx_n, first_k, unstable, pulses;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Bitwise CRC8 (poly 0xD5), data taken MSB first.
  function automatic logic [7:0] crc_model(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int b = 7; b >= 0; b--) begin
      fb = c[7] ^ d[b];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'hD5 : 8'h00);
    end
    return c;
  endfunction

  function automatic logic [255:0] v2_frame(input logic [7:0] dir, input logic [15:0] cmd,
                                            input int plen, input logic [79:0] pl,
                                            input logic corrupt);
    logic [255:0] f;
    logic [7:0]   crc, b;
    logic [7:0]   h[5];
    f = '0;
    crc = 8'h00;
    f = {f[247:0], 8'h24};
    f = {f[247:0], 8'h58};
    f = {f[247:0], dir};
    h[0] = 8'h00; h[1] = cmd[7:0]; h[2] = cmd[15:8]; h[3] = 8'(plen); h[4] = 8'h00;
    for (int j = 0; j < 5; j++) begin
      f = {f[247:0], h[j]};
      crc = crc_model(crc, h[j]);
    end
    for (int j = 0; j < plen; j++) begin
      b = pl[8*(plen-1-j) +: 8];
      f = {f[247:0], b};
      crc = crc_model(crc, b);
    end
    f = {f[247:0], crc ^ {7'b0, corrupt}};
    return f;
  endfunction

  task automatic send(input logic [255:0] f, input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = f[8*(len-1-i) +: 8];
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Samples at negedges; k=0 is the cycle right after the last request byte.
  task automatic recv(input int mode, input int cycles);
    logic       stall;
    logic [7:0] held;
    rx_n = 0; first_k = -1; unstable = 0; pulses = 0; stall = 1'b0; held = 8'h00;
    for (int k = 0; k < cycles; k++) begin
      if (k > 0) @(negedge clk);
      tx_ready = (mode == 0) ? 1'b1 : (k % 3 == 2);
      if (stall && (!tx_valid || tx_data !== held)) unstable++;
      if (tx_valid && first_k < 0) first_k = k;
      if (pt_req) pulses++;
      if (tx_valid && tx_ready) begin
        if (rx_n < 32) rx_buf[rx_n] = tx_data;
        rx_n++;
      end
      stall = tx_valid && !tx_ready;
      held  = tx_data;
    end
    tx_ready = 1'b0;
  endtask

  function automatic logic [255:0] got_vec();
    logic [255:0] g;
    g = '0;
    for (int j = 0; j < rx_n && j < 32; j++) g = {g[247:0], rx_buf[j]};
    return g;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    api = 32'h0000_0126; variant = 32'h4C46_5442;

    vecs[0]  = '{48'h244D3C000101, 6, 72'h244D3E030101260124, 9, 0, 16'd0, 8'h00, 0};
    vecs[1]  = '{48'h244D3C000303, 6, 72'h244D3E030304050100, 9, 1, 16'd0, 8'h00, 0};
    vecs[2]  = '{48'h244D3C006363, 6, 48'h244D21006363, 6, 0, 16'd0, 8'h00, 0};
    vecs[3]  = '{48'h244D3C000102, 6, 256'h0, 0, 0, 16'd1, 8'h00, 0};
    vecs[4]  = '{32'h244D3C50, 4, 256'h0, 0, 0, 16'd2, 8'h00, 0};
    vecs[5]  = '{48'h244D3C000202, 6, 80'h244D3E04024254464C1A, 10, 1, 16'd2, 8'h00, 0};
    vecs[6]  = '{48'h244D3C006464, 6, 104'h244D3E07640100000000000062, 13, 0, 16'd2, 8'h00, 0};
    vecs[7]  = '{64'h244D3C0263AA559E, 8, 48'h244D21006363, 6, 0, 16'd2, 8'h00, 0};
    vecs[8]  = '{48'h244D3C00F5F5, 6, 56'h244D3E01F5FF0B, 7, 0, 16'd2, 8'hFF, 1};
    vecs[9]  = '{64'h244D244D3C000101, 8, 72'h244D3E030101260124, 9, 0, 16'd2, 8'hFF, 0};
    vecs[10] = '{v2_frame(8'h3C, 16'h0001, 0, 80'h0, 1'b0), 9,
                 v2_frame(8'h3E, 16'h0001, 3, 80'h012601, 1'b0), 12, 0, 16'd2, 8'hFF, 0};
    vecs[11] = '{v2_frame(8'h3C, 16'h00F5, 1, 80'h07, 1'b0), 10,
                 v2_frame(8'h3E, 16'h00F5, 1, 80'h07, 1'b0), 10, 1, 16'd2, 8'h07, 1};
    vecs[12] = '{v2_frame(8'h3C, 16'h0101, 0, 80'h0, 1'b0), 9,
                 v2_frame(8'h21, 16'h0101, 0, 80'h0, 1'b0), 9, 0, 16'd2, 8'h07, 0};
    vecs[13] = '{v2_frame(8'h3C, 16'h0001, 0, 80'h0, 1'b1), 9, 256'h0, 0, 0, 16'd3, 8'h07, 0};
    vecs[14] = '{v2_frame(8'h3C, 16'h0065, 0, 80'h0, 1'b0), 9,
                 v2_frame(8'h3E, 16'h0065, 10, 80'h0, 1'b0), 19, 1, 16'd3, 8'h07, 0};
    // LENL=0, LENH=1: only a full 16-bit length compare rejects this.
    vecs[15] = '{64'h24583C0001000001, 8, 256'h0, 0, 0, 16'd4, 8'h07, 0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset tx_valid", tx_valid, 1'b0);
    check("reset tx_data", tx_data, 8'h00);
    check("reset active", active, 1'b0);
    check("reset err_count", err_cnt, 16'h0);
    check("reset pt_req/arg", {pt_req, pt_arg}, 9'h0);

    for (int i = 0; i < 16; i++) begin
      send(vecs[i].req, vecs[i].req_len);
      recv(vecs[i].mode, 150);
      check($sformatf("vec%0d byte count", i), rx_n, vecs[i].rsp_len);
      check($sformatf("vec%0d reply", i), got_vec(), vecs[i].rsp);
      if (vecs[i].rsp_len > 0) check($sformatf("vec%0d first-$ latency", i), first_k, 1);
      check($sformatf("vec%0d data stable while stalled", i), unstable, 0);
      check($sformatf("vec%0d passthrough pulses", i), pulses, vecs[i].pulse);
      check($sformatf("vec%0d err_count", i), err_cnt, vecs[i].err);
      check($sformatf("vec%0d passthrough_arg", i), pt_arg, vecs[i].arg);
      check($sformatf("vec%0d active at end", i), active, 1'b0);
    end

    // Stalled frame: timeout must drop it without counting an error.
    send(48'h244D3C, 3);
    repeat (500) @(negedge clk);
    check("timeout active mid-gap", active, 1'b1);
    repeat (505) @(negedge clk);
    check("timeout active after gap", active, 1'b0);
    check("timeout err_count", err_cnt, 16'd4);
    send(vecs[0].req, vecs[0].req_len);
    recv(0, 60);
    check("post-timeout reply", got_vec(), vecs[0].rsp);
    check("post-timeout byte count", rx_n, 9);

    // Reset while a reply is mid-flight.
    send(vecs[1].req, vecs[1].req_len);
    first_k = -1;
    for (int k = 0; k < 10 && first_k < 0; k++) begin
      if (tx_valid) first_k = k;
      else @(negedge clk);
    end
    check("reset-test reply started", tx_valid, 1'b1);
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    tx_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mid-reply reset tx_valid", tx_valid, 1'b0);
    check("mid-reply reset active", active, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("mid-reply reset stays quiet", tx_valid, 1'b0);
    send(vecs[0].req, vecs[0].req_len);
    recv(0, 60);
    check("post-reset reply", got_vec(), vecs[0].rsp);
    check("post-reset byte count", rx_n, 9);
    check("post-reset err_count", err_cnt, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
